// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding and constants for the load/store alignment unit
package lsu_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} lsu_state_t;
  localparam logic [3:0] IDLE_XFER_SIZE = 4'd8;
endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - zero/sign extension of the low size bytes of a load buffer
module load_extend (
  input  logic [63:0] rbuf,
  input  logic [3:0]  size,
  input  logic        sign_ext,
  output logic [63:0] data
);
  always_comb begin
    data = rbuf;
    case (size)
      4'd1:    data = {{56{sign_ext & rbuf[7]}},  rbuf[7:0]};
      4'd2:    data = {{48{sign_ext & rbuf[15]}}, rbuf[15:0]};
      4'd4:    data = {{32{sign_ext & rbuf[31]}}, rbuf[31:0]};
      default: data = rbuf;
    endcase
  end
endmodule

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - bounds check, aligned/byte-serial datamem access, extended load response
module lsu_align
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_address,
  input  logic [3:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_error,
  output logic [63:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [63:0] mem_write_data,
  output logic [3:0]  mem_xfer_size,
  input  logic [63:0] mem_read_data
);
  lsu_state_t  state, state_next;
  logic [2:0]  idx;
  logic        wr_q, sign_q, err_q;
  logic [63:0] addr_q, wdata_q, rbuf;
  logic [3:0]  size_q;
  logic        size_ok, req_err, aligned, last_byte, we_raw;
  logic [64:0] end_addr;
  logic [63:0] ext_data;

  // 65-bit sum so an address near 2^64 cannot wrap past the bounds check
  assign size_ok   = (req_size == 4'd1) || (req_size == 4'd2) || (req_size == 4'd4) || (req_size == 4'd8);
  assign end_addr  = {1'b0, req_address} + 65'(req_size);
  assign req_err   = !size_ok || (end_addr > 65'(MEM_BYTES));
  assign aligned   = (addr_q & (64'(size_q) - 64'd1)) == 64'd0;
  assign last_byte = ({1'b0, idx} == (size_q - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      idx     <= '0;
      wr_q    <= 1'b0;
      sign_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rbuf    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (req_valid) begin
          wr_q    <= req_write;
          addr_q  <= req_address;
          size_q  <= req_size;
          sign_q  <= req_signed;
          wdata_q <= req_wdata;
          err_q   <= req_err;
          idx     <= '0;
          rbuf    <= '0;
        end
        ACCESS: begin
          if (aligned) begin
            if (!wr_q) rbuf <= mem_read_data;
          end else begin
            if (!wr_q) rbuf[{idx, 3'b000} +: 8] <= mem_read_data[7:0];
            idx <= idx + 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next     = state;
    req_ready      = 1'b0;
    resp_valid     = 1'b0;
    we_raw         = 1'b0;
    mem_read_enable = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    mem_xfer_size  = IDLE_XFER_SIZE;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        we_raw          = wr_q;
        mem_read_enable = !wr_q;
        if (aligned) begin
          mem_address    = addr_q;
          mem_xfer_size  = size_q;
          mem_write_data = wdata_q;
          state_next     = RESP;
        end else begin
          mem_address    = addr_q + 64'(idx);
          mem_xfer_size  = 4'd1;
          mem_write_data = {56'd0, wdata_q[{idx, 3'b000} +: 8]};
          if (last_byte) state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_write_enable = we_raw & ~reset;

  load_extend u_load_extend (
    .rbuf     (rbuf),
    .size     (size_q),
    .sign_ext (sign_q),
    .data     (ext_data)
  );

  assign resp_rdata = (state == RESP && !wr_q && !err_q) ? ext_data : 64'd0;
  assign resp_error = (state == RESP) && err_q;
endmodule

// File: tb/tb_lsu_align.sv
// tb/tb_lsu_align.sv - scoreboard bench for lsu_align with a byte-array datamem model
module tb_lsu_align;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0, resp_ready = 1'b0;
  logic [63:0] req_address = '0, req_wdata = '0;
  logic [3:0]  req_size = 4'd8;
  logic        req_ready, resp_valid, resp_error;
  logic [63:0] resp_rdata, mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable;
  logic [3:0]  mem_xfer_size;

  always #5 clk = ~clk;

  lsu_align #(.MEM_BYTES(1024)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .mem_address(mem_address),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_write_data(mem_write_data), .mem_xfer_size(mem_xfer_size),
    .mem_read_data(mem_read_data)
  );

  logic [7:0] mem [0:1023];

  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++)
      if (i < int'(mem_xfer_size))
        mem_read_data[8*i +: 8] = mem[(int'(mem_address[9:0]) + i) & 1023];
  end

  always @(posedge clk)
    if (mem_write_enable)
      for (int i = 0; i < 8; i++)
        if (i < int'(mem_xfer_size))
          mem[(int'(mem_address[9:0]) + i) & 1023] <= mem_write_data[8*i +: 8];

  typedef struct { logic [63:0] rdata; logic err; int lat; int nwe; int nre; } exp_t;
  typedef struct { logic [63:0] a; logic [63:0] d; logic [3:0] s; } wr_t;
  exp_t sb[$];
  wr_t  wlog[$];
  int   n_vec = 0, n_err = 0;
  int   nwe_tot = 0, nre_tot = 0;

  always @(negedge clk) begin
    if (mem_write_enable) begin
      nwe_tot++;
      wlog.push_back('{a: mem_address, d: mem_write_data, s: mem_xfer_size});
    end
    if (mem_read_enable) nre_tot++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic run_req(input logic wr, input logic [63:0] a, input logic [3:0] sz, input logic sg,
                         input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_xfers, input int hold);
    exp_t e;
    int base_we, base_re, lat;
    logic [63:0] rd0;
    e.rdata = exp_rd; e.err = exp_err; e.lat = exp_lat;
    e.nwe = wr ? exp_xfers : 0;
    e.nre = wr ? 0 : exp_xfers;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = wr; req_address = a; req_size = sz; req_signed = sg; req_wdata = wd;
    sb.push_back(e);
    base_we = nwe_tot; base_re = nre_tot;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    req_valid = 1'b0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    e = sb.pop_front();
    check("resp_valid", 64'(resp_valid), 64'd1);
    check("latency", 64'(lat), 64'(e.lat));
    check("resp_rdata", resp_rdata, e.rdata);
    check("resp_error", 64'(resp_error), 64'(e.err));
    check("write_xfers", 64'(nwe_tot - base_we), 64'(e.nwe));
    check("read_xfers", 64'(nre_tot - base_re), 64'(e.nre));
    rd0 = resp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_rdata", resp_rdata, rd0);
      check("hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    resp_ready = 1'b0;
    check("back_idle_ready", 64'(req_ready), 64'd1);
    check("back_idle_valid", 64'(resp_valid), 64'd0);
  endtask

  initial begin
    int wl0;
    logic [63:0] exp_addr [4];
    logic [63:0] exp_byte [4];
    exp_addr = '{64'd5, 64'd6, 64'd7, 64'd8};
    exp_byte = '{64'hDD, 64'hCC, 64'hBB, 64'hAA};
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_error", 64'(resp_error), 64'd0);
    check("rst_mem_we", 64'(mem_write_enable), 64'd0);
    check("rst_mem_re", 64'(mem_read_enable), 64'd0);
    check("rst_mem_addr", mem_address, 64'd0);
    check("rst_mem_wdata", mem_write_data, 64'd0);
    check("rst_mem_size", 64'(mem_xfer_size), 64'd8);
    reset = 1'b0;

    wl0 = wlog.size();
    run_req(1'b1, 64'd16, 4'd8, 1'b0, 64'h1122334455667788, 64'd0, 1'b0, 2, 1, 0);
    if (wlog.size() > wl0) begin
      check("st8_addr", wlog[wl0].a, 64'd16);
      check("st8_size", 64'(wlog[wl0].s), 64'd8);
      check("st8_data", wlog[wl0].d, 64'h1122334455667788);
    end
    run_req(1'b0, 64'd16, 4'd8, 1'b1, 64'd0, 64'h1122334455667788, 1'b0, 2, 1, 0);

    wl0 = wlog.size();
    run_req(1'b1, 64'd5, 4'd4, 1'b0, 64'h00000000AABBCCDD, 64'd0, 1'b0, 5, 4, 0);
    for (int i = 0; i < 4; i++)
      if (wlog.size() > wl0 + i) begin
        check("split_addr", wlog[wl0+i].a, exp_addr[i]);
        check("split_data", wlog[wl0+i].d & 64'hFF, exp_byte[i]);
        check("split_size", 64'(wlog[wl0+i].s), 64'd1);
      end
    run_req(1'b0, 64'd5, 4'd4, 1'b0, 64'd0, 64'h00000000AABBCCDD, 1'b0, 5, 4, 0);
    run_req(1'b0, 64'd7, 4'd2, 1'b1, 64'd0, 64'hFFFFFFFFFFFFAABB, 1'b0, 3, 2, 0);

    run_req(1'b1, 64'd3, 4'd1, 1'b0, 64'h80, 64'd0, 1'b0, 2, 1, 0);
    run_req(1'b0, 64'd3, 4'd1, 1'b1, 64'd0, 64'hFFFFFFFFFFFFFF80, 1'b0, 2, 1, 0);
    run_req(1'b0, 64'd3, 4'd1, 1'b0, 64'd0, 64'h80, 1'b0, 2, 1, 0);

    run_req(1'b0, 64'd1020, 4'd8, 1'b0, 64'd0, 64'd0, 1'b1, 1, 0, 0);
    run_req(1'b0, 64'd0, 4'd3, 1'b0, 64'd0, 64'd0, 1'b1, 1, 0, 0);
    run_req(1'b1, 64'd1020, 4'd8, 1'b0, 64'hFFFF, 64'd0, 1'b1, 1, 0, 0);
    run_req(1'b0, 64'd1020, 4'd4, 1'b0, 64'd0, 64'd0, 1'b0, 2, 1, 0);

    run_req(1'b0, 64'd16, 4'd8, 1'b0, 64'd0, 64'h1122334455667788, 1'b0, 2, 1, 5);

    mem[11] = 8'hEE;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_address = 64'd9; req_size = 4'd8;
    req_signed = 1'b0; req_wdata = 64'h0102030405060708;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_byte9", 64'(mem[9]), 64'h08);
    check("rstmid_byte10", 64'(mem[10]), 64'h07);
    check("rstmid_byte11", 64'(mem[11]), 64'hEE);
    check("rstmid_req_ready", 64'(req_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rstmid_no_resp", 64'(resp_valid), 64'd0);
    end
    run_req(1'b0, 64'd11, 4'd1, 1'b0, 64'd0, 64'hEE, 1'b0, 2, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
